// File: rtl/btn_conditioner.sv
// btn_conditioner: five independent push-button channels, each with a
// two-flop synchronizer, a consecutive-sample debouncer and registered
// one-cycle press/release strobes.
// Optional auto-repeat of the press strobe while a button stays held is
// compiled in when the macro BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_btn,
  output logic [4:0] o_held,
  output logic [4:0] o_press,
  output logic [4:0] o_release
);

  localparam int NUM_BTN = 5;
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(REP_MAX + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
`endif

  // Channel state is implied by the debounced level and the disagreement count.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } state_t;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    logic             sync1_reg;
    logic             s_reg;
    logic             d_reg;
    logic             d_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             press_reg;
    logic             press_next;
    logic             release_reg;
    logic             release_next;
    logic             rise;
    logic             fall;
    state_t           state;

    // Two-flop synchronizer bringing the raw pin level into clk.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_reg <= 1'b0;
        s_reg     <= 1'b0;
      end else begin
        sync1_reg <= i_btn[gi];
        s_reg     <= sync1_reg;
      end
    end

    assign state = d_reg ? ((cnt_reg == '0) ? HELD : REL_PEND)
                         : ((cnt_reg == '0) ? IDLE : PRESS_PEND);

    // Debounce next-state: the level flips only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
      d_next   = d_reg;
      cnt_next = cnt_reg;
      rise     = 1'b0;
      fall     = 1'b0;
      case (state)
        IDLE, HELD: begin
          if (s_reg != d_reg) begin
            cnt_next = CNT_W'(1);
          end
        end
        default: begin
          if (s_reg == d_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            d_next   = s_reg;
            cnt_next = '0;
            rise     = s_reg;
            fall     = ~s_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    logic              rfirst_reg;
    logic              rfirst_next;
    logic [RCNT_W-1:0] rcnt_reg;
    logic [RCNT_W-1:0] rcnt_next;
    logic              rep_tick;

    // Repeat timer: first tick REPEAT_DELAY after the press, then every
    // REPEAT_PERIOD; the release edge always wins over a due repeat.
    always_comb begin
      rcnt_next   = rcnt_reg;
      rfirst_next = rfirst_reg;
      rep_tick    = 1'b0;
      if (rise) begin
        rcnt_next   = '0;
        rfirst_next = 1'b1;
      end else if (fall) begin
        rcnt_next = '0;
      end else if (state == HELD || state == REL_PEND) begin
        if (rcnt_reg == (rfirst_reg ? DELAY_LAST : PERIOD_LAST)) begin
          rep_tick    = 1'b1;
          rcnt_next   = '0;
          rfirst_next = 1'b0;
        end else begin
          rcnt_next = rcnt_reg + 1'b1;
        end
      end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rcnt_reg   <= '0;
        rfirst_reg <= 1'b0;
      end else begin
        rcnt_reg   <= rcnt_next;
        rfirst_reg <= rfirst_next;
      end
    end

    assign press_next = rise | rep_tick;
`else
    assign press_next = rise;
`endif

    assign release_next = fall;

    // Debounce state and registered one-cycle strobes.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d_reg       <= 1'b0;
        cnt_reg     <= '0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        d_reg       <= d_next;
        cnt_reg     <= cnt_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    assign o_held[gi]    = d_reg;
    assign o_press[gi]   = press_reg;
    assign o_release[gi] = release_reg;
  end

endmodule
